// File: rtl/dmem_initiator.sv
// dmem_initiator: pipeline-side initiator for the data memory stall handshake.
// Optional misaligned-access trapping is enabled by defining DMEM_MISALIGN_TRAP_EN.
module dmem_initiator #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_write_data,
  output logic        dmem_memread,
  output logic        dmem_memwrite,
  output logic [3:0]  dmem_sign_mask,
  input  logic [31:0] dmem_read_data,
  input  logic        dmem_clk_stall
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    WAIT_DONE,
    RESP
  } state_t;

  // cnt_q counts completed wait cycles, so the current wait cycle is
  // number cnt_q+1; the last allowed one is TIMEOUT_CYCLES-1.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 2);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] cnt_q;
  logic       write_q;
  logic       accept;
  logic       misalign;
  logic       to_hit;
  logic       done_ok;
  logic       to_err;
  logic [2:0] size_mask;

  assign req_ready     = (state_q == IDLE) & ~dmem_clk_stall;
  assign accept        = req_valid & req_ready;
  assign to_hit        = (cnt_q == TO_LAST);
  assign rsp_valid     = (state_q == RESP);
  assign dmem_memread  = (state_q == ISSUE) & ~write_q;
  assign dmem_memwrite = (state_q == ISSUE) & write_q;

`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalign = ((req_size == 2'd1) & req_addr[0])
                  | (req_size[1] & (|req_addr[1:0]));
`else
  assign misalign = 1'b0;
`endif

  // Access size to memory lane-mask bits; size 3 behaves as a word.
  always_comb begin
    size_mask = 3'b111;
    unique case (1'b1)
      (req_size == 2'd0): size_mask = 3'b001;
      (req_size == 2'd1): size_mask = 3'b011;
      default:            size_mask = 3'b111;
    endcase
  end

  // Next-state logic plus the two ways a wait can end.
  always_comb begin
    state_d = state_q;
    done_ok = 1'b0;
    to_err  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = misalign ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (dmem_clk_stall) begin
          state_d = WAIT_DONE;
        end else if (to_hit) begin
          state_d = RESP;
          to_err  = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!dmem_clk_stall) begin
          state_d = RESP;
          done_ok = 1'b1;
        end else if (to_hit) begin
          state_d = RESP;
          to_err  = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout counter: cleared on issue, counts wait cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == ISSUE) begin
      cnt_q <= '0;
    end else if ((state_q == WAIT_ACK) || (state_q == WAIT_DONE)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  // Memory-side request registers, loaded only on acceptance.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dmem_addr       <= '0;
      dmem_write_data <= '0;
      dmem_sign_mask  <= '0;
      write_q         <= 1'b0;
    end else if (accept) begin
      dmem_addr       <= req_addr;
      dmem_write_data <= req_wdata;
      dmem_sign_mask  <= {~req_write & req_signed, size_mask};
      write_q         <= req_write;
    end
  end

  // Response data and error, held until the next response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept & misalign) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end else if (done_ok) begin
      rsp_rdata <= write_q ? 32'h0 : dmem_read_data;
      rsp_err   <= 1'b0;
    end else if (to_err) begin
      rsp_rdata <= '0;
      rsp_err   <= 1'b1;
    end
  end

endmodule
